// File: rtl/competition_pkg.sv
// rtl/competition_pkg.sv - state encoding, default widths and score arithmetic for the quiz core
package competition_pkg;

  localparam int DEF_MAX_PLAYERS = 8;
  localparam int DEF_SCORE_W     = 7;
  localparam int DEF_TIME_W      = 7;
  localparam int DEF_QCNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_ANSWER  = 3'd3,
    ST_SHOW    = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  function automatic int unsigned score_add_sat(input int unsigned score,
                                                input int unsigned inc,
                                                input int unsigned max_val);
    return (score + inc > max_val) ? max_val : score + inc;
  endfunction

  function automatic int unsigned score_sub_floor(input int unsigned score,
                                                  input int unsigned dec);
    return (score > dec) ? score - dec : 32'd0;
  endfunction

endpackage

// File: rtl/buzz_priority_arbiter.sv
// rtl/buzz_priority_arbiter.sv - combinational masked lowest-index picker with valid flag
module buzz_priority_arbiter #(
  parameter int MAX_PLAYERS = 8
) (
  input  logic [MAX_PLAYERS-1:0] i_req,
  input  logic [MAX_PLAYERS-1:0] i_mask,
  output logic                   o_valid,
  output logic [3:0]             o_index
);

  // Scanning downward lets the lowest qualifying index overwrite last.
  always_comb begin
    o_valid = 1'b0;
    o_index = 4'd0;
    for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
      if (i_req[i] && i_mask[i]) begin
        o_valid = 1'b1;
        o_index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/competition_arbiter.sv
// rtl/competition_arbiter.sv - quiz core: questions, buzz arbitration, countdown, scoring (optional FALSE_START_EN)
module competition_arbiter
  import competition_pkg::*;
#(
  parameter int MAX_PLAYERS = DEF_MAX_PLAYERS,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int TIME_W      = DEF_TIME_W,
  parameter int QCNT_W      = DEF_QCNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick_1s,
  input  logic                           start,
  input  logic                           open_q,
  input  logic                           judge_ok,
  input  logic                           judge_fail,
  input  logic [MAX_PLAYERS-1:0]         buzz,
  input  logic [4:0]                     player_count,
  input  logic [QCNT_W-1:0]              question_count,
  input  logic [TIME_W-1:0]              answer_time,
  input  logic [SCORE_W-1:0]             win_score,
  input  logic [3:0]                     success_score,
  input  logic [3:0]                     fail_score,
  output logic [2:0]                     state,
  output logic [3:0]                     answerer,
  output logic [TIME_W-1:0]              time_left,
  output logic [MAX_PLAYERS*SCORE_W-1:0] scores,
  output logic [MAX_PLAYERS-1:0]         lockout,
  output logic [QCNT_W-1:0]              play_count,
  output logic [3:0]                     winner,
  output logic                           winner_valid
);

  localparam int unsigned SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;
  localparam logic [4:0]  MAX_P5    = 5'(MAX_PLAYERS);

  state_t r_state, w_state_next;

  logic [4:0]              r_pc;
  logic [QCNT_W-1:0]       r_qc;
  logic [TIME_W-1:0]       r_at;
  logic [SCORE_W-1:0]      r_ws;
  logic [3:0]              r_ss;
  logic [3:0]              r_fs;
  logic [SCORE_W-1:0]      r_score [MAX_PLAYERS];
  logic [MAX_PLAYERS-1:0]  r_lockout;
  logic [3:0]              r_answerer;
  logic [TIME_W-1:0]       r_time_left;
  logic [QCNT_W-1:0]       r_play;
  logic [3:0]              r_winner;
  logic                    r_winner_valid;

  logic [MAX_PLAYERS-1:0]  w_active;
  logic [MAX_PLAYERS-1:0]  w_at_win;
  logic                    w_cfg_ok;
  logic                    w_grant_valid;
  logic [3:0]              w_grant_idx;
  logic                    w_win_valid;
  logic [3:0]              w_win_idx;
  logic                    w_timeout;
  logic                    w_all_locked;
  logic                    w_start_ev;
  logic                    w_grant;
  logic                    w_ok;
  logic                    w_fail;
  logic                    w_enter_show;
  logic                    w_show_exit;

  for (genvar g = 0; g < MAX_PLAYERS; g++) begin : g_player
    assign w_active[g]                  = (5'(g) < r_pc);
    assign w_at_win[g]                  = (r_score[g] >= r_ws);
    assign scores[g*SCORE_W +: SCORE_W] = r_score[g];
  end

  assign w_cfg_ok     = (player_count != 5'd0) && (player_count <= MAX_P5) && (question_count != '0);
  assign w_all_locked = ((w_active & ~r_lockout) == '0);
  // answer_time==0 must expire immediately, without waiting for a tick
  assign w_timeout    = (r_time_left == '0) || (tick_1s && (r_time_left == TIME_W'(1)));

  buzz_priority_arbiter #(.MAX_PLAYERS(MAX_PLAYERS)) u_buzz_arb (
    .i_req   (buzz),
    .i_mask  (w_active & ~r_lockout),
    .o_valid (w_grant_valid),
    .o_index (w_grant_idx)
  );

  buzz_priority_arbiter #(.MAX_PLAYERS(MAX_PLAYERS)) u_win_arb (
    .i_req   (w_at_win),
    .i_mask  (w_active),
    .o_valid (w_win_valid),
    .o_index (w_win_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_ev   = 1'b0;
    w_grant      = 1'b0;
    w_ok         = 1'b0;
    w_fail       = 1'b0;
    w_enter_show = 1'b0;
    w_show_exit  = 1'b0;
    case (r_state)
      ST_IDLE, ST_FINISH: begin
        if (start && w_cfg_ok) begin
          w_start_ev   = 1'b1;
          w_state_next = ST_READING;
        end
      end
      ST_READING: begin
        if (open_q) w_state_next = ST_OPEN;
      end
      ST_OPEN: begin
        if (w_grant_valid) begin
          w_grant      = 1'b1;
          w_state_next = ST_ANSWER;
        end else if (w_all_locked) begin
          w_enter_show = 1'b1;
          w_state_next = ST_SHOW;
        end
      end
      ST_ANSWER: begin
        if (judge_ok) begin
          w_ok         = 1'b1;
          w_enter_show = 1'b1;
          w_state_next = ST_SHOW;
        end else if (judge_fail || w_timeout) begin
          w_fail       = 1'b1;
          w_state_next = ST_OPEN;
        end
      end
      ST_SHOW: begin
        if (w_win_valid || (r_play == r_qc)) begin
          w_show_exit  = 1'b1;
          w_state_next = ST_FINISH;
        end else if (open_q) begin
          w_show_exit  = 1'b1;
          w_state_next = ST_READING;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc           <= '0;
      r_qc           <= '0;
      r_at           <= '0;
      r_ws           <= '0;
      r_ss           <= '0;
      r_fs           <= '0;
      r_lockout      <= '0;
      r_answerer     <= '0;
      r_time_left    <= '0;
      r_play         <= '0;
      r_winner       <= '0;
      r_winner_valid <= 1'b0;
      for (int i = 0; i < MAX_PLAYERS; i++) r_score[i] <= '0;
    end else begin
      if (w_start_ev) begin
        r_pc           <= player_count;
        r_qc           <= question_count;
        r_at           <= answer_time;
        r_ws           <= win_score;
        r_ss           <= success_score;
        r_fs           <= fail_score;
        r_play         <= '0;
        r_lockout      <= '0;
        r_winner       <= '0;
        r_winner_valid <= 1'b0;
        for (int i = 0; i < MAX_PLAYERS; i++) r_score[i] <= '0;
      end
`ifdef FALSE_START_EN
      if (r_state == ST_READING) begin
        for (int i = 0; i < MAX_PLAYERS; i++) begin
          if (buzz[i] && w_active[i]) begin
            r_score[i]   <= SCORE_W'(score_sub_floor(32'(r_score[i]), 32'(r_fs)));
            r_lockout[i] <= 1'b1;
          end
        end
      end
`endif
      if (w_grant) begin
        r_answerer  <= w_grant_idx;
        r_time_left <= r_at;
      end
      if ((r_state == ST_ANSWER) && tick_1s)
        r_time_left <= (r_time_left <= TIME_W'(1)) ? '0 : r_time_left - TIME_W'(1);
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        if (4'(i) == r_answerer) begin
          if (w_ok) begin
            r_score[i] <= SCORE_W'(score_add_sat(32'(r_score[i]), 32'(r_ss), SCORE_MAX));
          end else if (w_fail) begin
            r_score[i]   <= SCORE_W'(score_sub_floor(32'(r_score[i]), 32'(r_fs)));
            r_lockout[i] <= 1'b1;
          end
        end
      end
      if (w_enter_show) r_play <= r_play + QCNT_W'(1);
      if (w_show_exit)  r_lockout <= '0;
      if ((r_state == ST_SHOW) && w_win_valid) begin
        r_winner       <= w_win_idx;
        r_winner_valid <= 1'b1;
      end
    end
  end

  assign state        = r_state;
  assign answerer     = r_answerer;
  assign time_left    = r_time_left;
  assign lockout      = r_lockout;
  assign play_count   = r_play;
  assign winner       = r_winner;
  assign winner_valid = r_winner_valid;

endmodule

// File: tb/tb_competition_arbiter.sv
// tb/tb_competition_arbiter.sv - directed and randomized bench for competition_arbiter against a behavioural model
module tb_competition_arbiter;

  localparam int MP   = 8;
  localparam int SW   = 7;
  localparam int TW   = 7;
  localparam int QW   = 4;
  localparam int SMAX = (1 << SW) - 1;
`ifdef FALSE_START_EN
  localparam int FS_LOCK = 1;
`else
  localparam int FS_LOCK = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           tick_1s = 1'b0;
  logic           start = 1'b0;
  logic           open_q = 1'b0;
  logic           judge_ok = 1'b0;
  logic           judge_fail = 1'b0;
  logic [MP-1:0]  buzz = '0;
  logic [4:0]     player_count = 5'd3;
  logic [QW-1:0]  question_count = 4'd4;
  logic [TW-1:0]  answer_time = 7'd5;
  logic [SW-1:0]  win_score = 7'd6;
  logic [3:0]     success_score = 4'd3;
  logic [3:0]     fail_score = 4'd2;
  logic [2:0]     state;
  logic [3:0]     answerer;
  logic [TW-1:0]  time_left;
  logic [MP*SW-1:0] scores;
  logic [MP-1:0]  lockout;
  logic [QW-1:0]  play_count;
  logic [3:0]     winner;
  logic           winner_valid;

  always #5 clk = ~clk;

  competition_arbiter #(.MAX_PLAYERS(MP), .SCORE_W(SW), .TIME_W(TW), .QCNT_W(QW)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .start(start), .open_q(open_q),
    .judge_ok(judge_ok), .judge_fail(judge_fail), .buzz(buzz),
    .player_count(player_count), .question_count(question_count),
    .answer_time(answer_time), .win_score(win_score),
    .success_score(success_score), .fail_score(fail_score),
    .state(state), .answerer(answerer), .time_left(time_left), .scores(scores),
    .lockout(lockout), .play_count(play_count), .winner(winner),
    .winner_valid(winner_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Behavioural model: plain integers, one step per clock.
  int m_state, m_ans, m_time, m_play, m_win, m_wv;
  int m_score [MP];
  bit m_lock  [MP];
  int c_pc, c_qc, c_at, c_ws, c_ss, c_fs;

  function automatic void clear_locks();
    for (int i = 0; i < MP; i++) m_lock[i] = 1'b0;
  endfunction

  function automatic void model_step(input bit rn, input bit st, input bit oq, input bit ok,
                                     input bit fl, input bit tk, input logic [MP-1:0] bz);
    int idx;
    int unlocked;
    bit to;
    int pcv, qcv;
    if (!rn) begin
      m_state = 0; m_ans = 0; m_time = 0; m_play = 0; m_win = 0; m_wv = 0;
      for (int i = 0; i < MP; i++) m_score[i] = 0;
      clear_locks();
      return;
    end
    pcv = int'(player_count);
    qcv = int'(question_count);
    case (m_state)
      0, 5: begin
        if (st && pcv >= 1 && pcv <= MP && qcv >= 1) begin
          c_pc = pcv; c_qc = qcv; c_at = int'(answer_time); c_ws = int'(win_score);
          c_ss = int'(success_score); c_fs = int'(fail_score);
          for (int i = 0; i < MP; i++) m_score[i] = 0;
          clear_locks();
          m_play = 0; m_win = 0; m_wv = 0; m_state = 1;
        end
      end
      1: begin
`ifdef FALSE_START_EN
        for (int i = 0; i < c_pc; i++) begin
          if (bz[i]) begin
            m_score[i] = (m_score[i] > c_fs) ? m_score[i] - c_fs : 0;
            m_lock[i]  = 1'b1;
          end
        end
`endif
        if (oq) m_state = 2;
      end
      2: begin
        idx = -1;
        unlocked = 0;
        for (int i = c_pc - 1; i >= 0; i--) begin
          if (!m_lock[i]) unlocked++;
          if (bz[i] && !m_lock[i]) idx = i;
        end
        if (idx >= 0) begin
          m_ans = idx; m_time = c_at; m_state = 3;
        end else if (unlocked == 0) begin
          m_state = 4; m_play++;
        end
      end
      3: begin
        to = (m_time == 0) || (tk && m_time == 1);
        if (tk) m_time = (m_time > 1) ? m_time - 1 : 0;
        if (ok) begin
          m_score[m_ans] = (m_score[m_ans] + c_ss > SMAX) ? SMAX : m_score[m_ans] + c_ss;
          m_state = 4; m_play++;
        end else if (fl || to) begin
          m_score[m_ans] = (m_score[m_ans] > c_fs) ? m_score[m_ans] - c_fs : 0;
          m_lock[m_ans]  = 1'b1;
          m_state = 2;
        end
      end
      4: begin
        idx = -1;
        for (int i = c_pc - 1; i >= 0; i--) if (m_score[i] >= c_ws) idx = i;
        if (idx >= 0) begin
          m_win = idx; m_wv = 1; m_state = 5; clear_locks();
        end else if (m_play == c_qc) begin
          m_state = 5; clear_locks();
        end else if (oq) begin
          m_state = 1; clear_locks();
        end
      end
      default: m_state = 0;
    endcase
  endfunction

  task automatic compare_all();
    logic [MP-1:0] lk;
    for (int i = 0; i < MP; i++) lk[i] = m_lock[i];
    check("state", 32'(state), m_state);
    check("answerer", 32'(answerer), m_ans);
    check("time_left", 32'(time_left), m_time);
    check("play_count", 32'(play_count), m_play % (1 << QW));
    check("winner_valid", 32'(winner_valid), m_wv);
    check("winner", 32'(winner), m_win);
    check("lockout", 32'(lockout), 32'(lk));
    for (int i = 0; i < MP; i++)
      check($sformatf("score%0d", i), 32'(scores[i*SW +: SW]), m_score[i]);
  endtask

  task automatic cyc(input bit rn, input bit st, input bit oq, input bit ok,
                     input bit fl, input bit tk, input logic [MP-1:0] bz);
    rst = rn; start = st; open_q = oq; judge_ok = ok; judge_fail = fl; tick_1s = tk; buzz = bz;
    model_step(rn, st, oq, ok, fl, tk, bz);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, 0, '0);
    check("rst_state", 32'(state), 0);
    check("rst_scores_any", 32'(|scores), 0);

    // Simultaneous buzz, then two correct answers for player 2 reach win_score.
    player_count = 5'd3; question_count = 4'd4; answer_time = 7'd5;
    win_score = 7'd6; success_score = 4'd3; fail_score = 4'd2;
    cyc(1, 1, 0, 0, 0, 0, '0);
    cyc(1, 0, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, 0, 8'b0000_0110);
    check("a_answerer", 32'(answerer), 1);
    check("a_state", 32'(state), 3);
    check("a_time", 32'(time_left), 5);
    cyc(1, 0, 0, 1, 0, 0, '0);
    check("a_score1", 32'(scores[1*SW +: SW]), 3);
    for (int q = 0; q < 2; q++) begin
      cyc(1, 0, 1, 0, 0, 0, '0);
      cyc(1, 0, 1, 0, 0, 0, '0);
      cyc(1, 0, 0, 0, 0, 0, 8'b0000_0100);
      cyc(1, 0, 0, 1, 0, 0, '0);
    end
    check("a_score2", 32'(scores[2*SW +: SW]), 6);
    idle();
    check("a_finish", 32'(state), 5);
    check("a_winner", 32'(winner), 2);
    check("a_wvalid", 32'(winner_valid), 1);

    // Timeout with floored score, second player fails, question exhausted.
    player_count = 5'd2; question_count = 4'd1; answer_time = 7'd2;
    win_score = 7'd20; success_score = 4'd1; fail_score = 4'd2;
    cyc(1, 1, 0, 0, 0, 0, '0);
    cyc(1, 0, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, 0, 8'b0000_0001);
    cyc(1, 0, 0, 0, 0, 1, '0);
    check("b_time1", 32'(time_left), 1);
    cyc(1, 0, 0, 0, 0, 1, '0);
    check("b_time0", 32'(time_left), 0);
    check("b_open", 32'(state), 2);
    check("b_lock0", 32'(lockout), 1);
    check("b_score0", 32'(scores[0 +: SW]), 0);
    cyc(1, 0, 0, 0, 0, 0, 8'b0000_0011);
    check("b_answerer", 32'(answerer), 1);
    cyc(1, 0, 0, 0, 1, 0, '0);
    idle();
    check("b_show", 32'(state), 4);
    check("b_play", 32'(play_count), 1);
    idle();
    check("b_finish", 32'(state), 5);
    check("b_wvalid", 32'(winner_valid), 0);

    // judge_ok beats a simultaneous final tick.
    question_count = 4'd3; answer_time = 7'd1; success_score = 4'd2;
    cyc(1, 1, 0, 0, 0, 0, '0);
    cyc(1, 0, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, 0, 8'b0000_0010);
    cyc(1, 0, 0, 1, 0, 1, '0);
    check("c_show", 32'(state), 4);
    check("c_score1", 32'(scores[1*SW +: SW]), 2);

    // READING buzz: penalised only when the false-start feature is built in.
    cyc(1, 0, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, 0, 8'b0000_0001);
    check("d_lock", 32'(lockout), FS_LOCK);
    check("d_state", 32'(state), 1);

    // Reset while answering.
    cyc(1, 0, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, 0, 8'b0000_0010);
    check("e_answer", 32'(state), 3);
    cyc(0, 0, 0, 0, 0, 0, '0);
    check("e_state", 32'(state), 0);
    check("e_scores_any", 32'(|scores), 0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        player_count   = 5'($urandom_range(0, 9));
        question_count = QW'($urandom_range(0, 15));
        answer_time    = TW'($urandom_range(0, 3));
        win_score      = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(100, 127))
                                                     : SW'($urandom_range(0, 12));
        success_score  = 4'($urandom_range(0, 15));
        fail_score     = 4'($urandom_range(0, 15));
      end
      cyc(($urandom_range(0, 599) != 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
          MP'($urandom & $urandom & $urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
